// File: rtl/alu_sched.sv
// Two-requester round-robin front end sharing one registered 32-bit ALU stage.
// Each accepted operation produces one tagged response: IDLE -> EXEC -> RESP -> IDLE.
module alu_sched #(
  parameter int DATA_W = 32,
  parameter int B_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [B_W-1:0]    req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [B_W-1:0]    req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_o,
  output logic              rsp_zero
);

  // Handshakes: a transfer happens on any rising edge where valid && ready are
  // both high; requesters hold valid/operands until then, rsp_* hold until rsp_ready.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic              grant_id;
  logic              accept;
  logic [2:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] alu_res;

  // Contention goes to the requester that was not served last.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? {{(DATA_W-B_W){1'b0}}, req1_b}
                           : {{(DATA_W-B_W){1'b0}}, req0_b};

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = b_q - a_q;
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q | b_q;
      3'b100:  alu_res = ~b_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_o      <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_o     <= alu_res;
          rsp_zero  <= (alu_res == '0);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares one registered 32-bit ALU between two independent requesters. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one request at a time, and the block executes it in an internal ALU stage. The result is returned on a single response channel tagged with the requester id and a zero flag. It sits between two command sources (for example, a sequencer and a debug port) and the ALU datapath.

## Interface
Parameters:
- DATA_W, 32, width of operand a and of the result
- B_W, 8, width of operand b; zero-extended to DATA_W before use

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  opcode for requester 0
- req0_a  in  DATA_W  operand a for requester 0
- req0_b  in  B_W  operand b for requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as the port-0 signals, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the result (0 or 1)
- rsp_o  out  DATA_W  ALU result
- rsp_zero  out  1  high when rsp_o == 0

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_o=0, rsp_zero=0.
  - Operand, op and id registers are cleared to 0.
  - last_grant=1, so requester 0 wins first.
- IDLE behaviour:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - reqN_ready is combinational: high only in IDLE and only for the granted requester.
  - On valid&&ready, latch op, a, zero-extended b and the id; set last_grant=id; go to EXEC.
  - If no request is valid, stay in IDLE and keep both ready signals low.
- EXEC behaviour: compute the result from the latched operands into the rsp_o/rsp_zero registers, set rsp_valid, go to RESP. Opcodes (bz = zero-extended b, all results modulo 2^DATA_W):
  - 000: a + bz
  - 001: bz − a (wraps; e.g. bz=0, a=1 gives 0xFFFF_FFFF)
  - 010: a & bz
  - 011: a | bz
  - 100: ~bz
  - 101–111: 0, which sets rsp_zero=1
- RESP behaviour:
  - rsp_valid, rsp_id, rsp_o and rsp_zero stay stable until rsp_ready is high.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
- Requests are never accepted in EXEC or RESP, so requesters must hold valid and their operands stable until ready.
- Dropping valid before grant is legal; the request is simply not taken.
- rsp_zero is registered together with rsp_o and always equals (rsp_o == 0).

## Timing
- Accept in cycle N (reqN_valid && reqN_ready at the edge) → EXEC in N+1 → rsp_valid high from N+2.
- Response handshake completes in cycle M → IDLE in M+1 → the next grant can occur in M+1.
- Peak throughput is one operation per 3 cycles, with rsp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Round-robin pointer rules:
  - last_grant updates only on an accepted request.
  - A cycle in which a single requester is served still updates last_grant.
- If rsp_ready is low, the block stalls in RESP indefinitely with outputs frozen. No request is accepted while stalled.
- Asserting rst in any state immediately forces IDLE and the reset values. Any in-flight operation or unconsumed response is discarded, and no response is produced for it after reset release.
- The first grant is possible in the first clk edge after rst deasserts.

## Test plan
- Reset then single request:
  - Stimulus: req0 op=000, a=0x0000_0001, b=0x05, rsp_ready=1.
  - Required: req0_ready in the accept cycle; rsp_valid 2 cycles later with rsp_o=0x0000_0006, rsp_id=0, rsp_zero=0.
- Opcode sweep on requester 1, with a=0x0000_00F0, b=0x3C:
  - 000 → 0x12C
  - 001 → 0xFFFF_FF4C
  - 010 → 0x30
  - 011 → 0xFC
  - 100 → 0xFFFF_FFC3
  - 111 → 0 with rsp_zero=1
  - Every result has rsp_id=1.
- Contention:
  - Stimulus: both requesters valid continuously for 6 operations after reset.
  - Required: grant order 0,1,0,1,0,1; rsp_id matches that order; no simultaneous readys.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles while in RESP, with req1 valid.
  - Required: rsp_o, rsp_id and rsp_zero stable; req1_ready stays 0; req1 is accepted the cycle after the response handshake.
- Zero-result flag:
  - Stimulus: op=001, a=0x0000_0007, b=0x07.
  - Required: rsp_o=0, rsp_zero=1.
- Reset mid-operation:
  - Stimulus: assert rst in EXEC, and separately in RESP.
  - Required: rsp_valid drops immediately; after release, no stale response appears; req0 wins the next contended grant.
